// File: rtl/instr_cycle_ctrl_pkg.sv
// Shared types for the GCore instruction-cycle sequencer: FSM states, opcode classes and the class decoder.
package gcore_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_EXEC,
    ST_WB,
    ST_HALT,
    ST_FAULT
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LDA,
    CLS_STA,
    CLS_HLT
  } opc_class_e;

  // Opcodes are zero-extended to this width before comparison
  localparam int OPC_MAX_W = 32;

  localparam logic [OPC_MAX_W-1:0] OPC_NOP    = 32'd0;
  localparam logic [OPC_MAX_W-1:0] OPC_ALU_LO = 32'd1;
  localparam logic [OPC_MAX_W-1:0] OPC_ALU_HI = 32'd7;
  localparam logic [OPC_MAX_W-1:0] OPC_LDA    = 32'd8;
  localparam logic [OPC_MAX_W-1:0] OPC_STA    = 32'd9;
  localparam logic [OPC_MAX_W-1:0] OPC_HLT    = 32'd15;

  function automatic opc_class_e opc_class(input logic [OPC_MAX_W-1:0] opc);
    opc_class_e cls;
    cls = CLS_NOP;
    if (opc == OPC_NOP)                             cls = CLS_NOP;
    else if (opc >= OPC_ALU_LO && opc <= OPC_ALU_HI) cls = CLS_ALU;
    else if (opc == OPC_LDA)                        cls = CLS_LDA;
    else if (opc == OPC_STA)                        cls = CLS_STA;
    else if (opc == OPC_HLT)                        cls = CLS_HLT;
    return cls;
  endfunction

endpackage

// File: rtl/instr_cycle_ctrl_if.sv
// Memory/datapath strobe bundle between the sequencer (master) and the datapath (slave).
interface instr_cycle_ctrl_if #(
  parameter int OPC_W = 4
);
  logic [OPC_W-1:0] opcode;
  logic             mem_ready;
  logic             mem_rd;
  logic             mem_wr;
  logic             ir_load;
  logic             pc_inc;
  logic             alu_en;
  logic             acc_write;

  modport master (
    input  opcode, mem_ready,
    output mem_rd, mem_wr, ir_load, pc_inc, alu_en, acc_write
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_rd, mem_wr, ir_load, pc_inc, alu_en, acc_write
  );
endinterface

// File: rtl/instr_cycle_ctrl_mem_wait_tmo.sv
// Memory wait-state counter; expired flags the cycle in which the count would reach 2**TMO_W-1.
module mem_wait_tmo #(
  parameter int TMO_W = 4
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clear,
  input  logic cnt_en,
  output logic expired
);
  localparam logic [TMO_W-1:0] CNT_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (cnt_en) cnt_d = cnt_q + TMO_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = cnt_en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/instr_cycle_ctrl.sv
// GCore instruction-cycle sequencer: FETCH -> LOAD -> EXEC -> WB with halt, resume and memory timeout.
// Optional macro SINGLE_STEP_EN adds a step input that runs one instruction out of HALT.
module instr_cycle_ctrl
  import gcore_ctrl_pkg::*;
#(
  parameter int OPC_W = 4,
  parameter int TMO_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 halt_req,
`ifdef SINGLE_STEP_EN
  input  logic                 step,
`endif
  instr_cycle_ctrl_if.master   bus,
  output logic                 busy,
  output logic                 halted,
  output logic                 fault,
  output logic [CNT_W-1:0]     instr_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OPC_W-1:0] opc;
  opc_class_e       cls;
  logic             wait_st;
  logic             tmo_expired;
  logic             stop;
  logic             retire;
  logic             mem_rd, mem_wr, ir_load, pc_inc, alu_en, acc_write;
`ifdef SINGLE_STEP_EN
  logic             step_q, step_d;
`endif

  assign opc = bus.opcode;
  assign cls = opc_class(OPC_MAX_W'(opc));

  // Memory-wait states: fetch, and the operand phase of LDA/STA
  assign wait_st = (state_q == ST_FETCH) ||
                   (state_q == ST_EXEC && (cls == CLS_LDA || cls == CLS_STA));

  mem_wait_tmo #(.TMO_W(TMO_W)) u_tmo (
    .clk_in  (clk_in),
    .rst     (rst),
    .clear   (!wait_st || bus.mem_ready),
    .cnt_en  (wait_st && !bus.mem_ready),
    .expired (tmo_expired)
  );

`ifdef SINGLE_STEP_EN
  assign stop = (state_q == ST_EXEC && cls == CLS_HLT) || halt_req || step_q;
`else
  assign stop = (state_q == ST_EXEC && cls == CLS_HLT) || halt_req;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retire    = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    alu_en    = 1'b0;
    acc_write = 1'b0;
`ifdef SINGLE_STEP_EN
    step_d    = step_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_rd = 1'b1;
        if (tmo_expired)        state_d = ST_FAULT;
        else if (bus.mem_ready) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (cls)
          CLS_ALU: begin
            alu_en  = 1'b1;
            state_d = ST_WB;
          end
          CLS_LDA: begin
            mem_rd = 1'b1;
            if (tmo_expired)        state_d = ST_FAULT;
            else if (bus.mem_ready) state_d = ST_WB;
          end
          CLS_STA: begin
            mem_wr = 1'b1;
            if (tmo_expired)        state_d = ST_FAULT;
            else if (bus.mem_ready) retire = 1'b1;
          end
          default: retire = 1'b1;
        endcase
      end
      ST_WB: begin
        acc_write = 1'b1;
        retire    = 1'b1;
      end
      ST_HALT: begin
        if (run && !halt_req) begin
          state_d = ST_FETCH;
        end
`ifdef SINGLE_STEP_EN
        else if (step && !run) begin
          state_d = ST_FETCH;
          step_d  = 1'b1;
        end
`endif
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase

    // Instruction boundary: the only place run/halt_req steer the sequence
    if (retire) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (stop)     state_d = ST_HALT;
      else if (run) state_d = ST_FETCH;
      else          state_d = ST_IDLE;
`ifdef SINGLE_STEP_EN
      step_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
`ifdef SINGLE_STEP_EN
      step_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef SINGLE_STEP_EN
      step_q  <= step_d;
`endif
    end
  end

  assign bus.mem_rd    = mem_rd;
  assign bus.mem_wr    = mem_wr;
  assign bus.ir_load   = ir_load;
  assign bus.pc_inc    = pc_inc;
  assign bus.alu_en    = alu_en;
  assign bus.acc_write = acc_write;

  assign busy      = !(state_q == ST_IDLE || state_q == ST_HALT || state_q == ST_FAULT);
  assign halted    = (state_q == ST_HALT);
  assign fault     = (state_q == ST_FAULT);
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_instr_cycle_ctrl.sv
// Directed-vector bench for instr_cycle_ctrl; expected per-cycle outputs are queued and checked by a monitor.
module tb_instr_cycle_ctrl;

  localparam logic [5:0] N  = 6'b000000;
  localparam logic [5:0] RD = 6'b100000;
  localparam logic [5:0] WR = 6'b010000;
  localparam logic [5:0] IP = 6'b001100;
  localparam logic [5:0] AL = 6'b000010;
  localparam logic [5:0] AC = 6'b000001;
  localparam logic [2:0] SI = 3'b000;
  localparam logic [2:0] SB = 3'b100;
  localparam logic [2:0] SH = 3'b010;
  localparam logic [2:0] SF = 3'b001;

  typedef struct {
    int          cyc;
    logic [5:0]  s;
    logic [2:0]  st;
    logic [15:0] c;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        halt_req = 1'b0;
  logic        step_in = 1'b0;
  logic        busy, halted, fault;
  logic [15:0] instr_cnt;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [5:0] act_s;
  logic [2:0] act_st;

  instr_cycle_ctrl_if #(.OPC_W(4)) bus ();

  instr_cycle_ctrl #(.OPC_W(4), .TMO_W(4), .CNT_W(16)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .run       (run),
    .halt_req  (halt_req),
`ifdef SINGLE_STEP_EN
    .step      (step_in),
`endif
    .bus       (bus),
    .busy      (busy),
    .halted    (halted),
    .fault     (fault),
    .instr_cnt (instr_cnt)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // ctl = {rst, run, halt_req, mem_ready, step}; expectations describe this cycle's outputs
  task automatic tick(input logic [4:0] ctl, input logic [3:0] op,
                      input logic [5:0] es, input logic [2:0] ess, input logic [15:0] ec);
    exp_t e;
    @(posedge clk_in);
    #1;
    rst           = ctl[4];
    run           = ctl[3];
    halt_req      = ctl[2];
    bus.mem_ready = ctl[1];
    step_in       = ctl[0];
    bus.opcode    = op;
    e.cyc = cyc;
    e.s   = es;
    e.st  = ess;
    e.c   = ec;
    exp_q.push_back(e);
  endtask

  always @(negedge clk_in) begin
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e  = exp_q.pop_front();
      act_s  = {bus.mem_rd, bus.mem_wr, bus.ir_load, bus.pc_inc, bus.alu_en, bus.acc_write};
      act_st = {busy, halted, fault};
      n_cmp++;
      $display("cyc %0d: strobes=%b status=%b instr_cnt=%0d", cyc, act_s, act_st, instr_cnt);
      if (act_s !== mon_e.s || act_st !== mon_e.st || instr_cnt !== mon_e.c) begin
        n_bad++;
        $display("FAIL cyc_%0d: got strobes=%b status=%b cnt=%0d, need strobes=%b status=%b cnt=%0d",
                 cyc, act_s, act_st, instr_cnt, mon_e.s, mon_e.st, mon_e.c);
      end
    end
  end

  initial begin
    bus.opcode    = 4'h0;
    bus.mem_ready = 1'b0;
    // reset held two cycles
    tick(5'b10000, 4'h0, N,  SI, 16'd0);
    tick(5'b10000, 4'h0, N,  SI, 16'd0);
    // opcode 0xC behaves as NOP; run low at retire returns to IDLE
    tick(5'b01010, 4'h0, N,  SI, 16'd0);
    tick(5'b00010, 4'h0, RD, SB, 16'd0);
    tick(5'b00010, 4'hC, IP, SB, 16'd0);
    tick(5'b00010, 4'hC, N,  SB, 16'd0);
    tick(5'b00010, 4'hC, N,  SI, 16'd1);
    // ALU 0x3
    tick(5'b01010, 4'hC, N,  SI, 16'd1);
    tick(5'b01010, 4'hC, RD, SB, 16'd1);
    tick(5'b01010, 4'h3, IP, SB, 16'd1);
    tick(5'b01010, 4'h3, AL, SB, 16'd1);
    tick(5'b01010, 4'h3, AC, SB, 16'd1);
    // LDA with three wait cycles in EXEC
    tick(5'b01010, 4'h3, RD, SB, 16'd2);
    tick(5'b01010, 4'h8, IP, SB, 16'd2);
    tick(5'b01000, 4'h8, RD, SB, 16'd2);
    tick(5'b01000, 4'h8, RD, SB, 16'd2);
    tick(5'b01000, 4'h8, RD, SB, 16'd2);
    tick(5'b01010, 4'h8, RD, SB, 16'd2);
    tick(5'b01010, 4'h8, AC, SB, 16'd2);
    // STA then HLT
    tick(5'b01010, 4'h8, RD, SB, 16'd3);
    tick(5'b01010, 4'h9, IP, SB, 16'd3);
    tick(5'b01010, 4'h9, WR, SB, 16'd3);
    tick(5'b01010, 4'h9, RD, SB, 16'd4);
    tick(5'b01010, 4'hF, IP, SB, 16'd4);
    tick(5'b00010, 4'hF, N,  SB, 16'd4);
    tick(5'b00010, 4'hF, N,  SH, 16'd5);
    tick(5'b01010, 4'hF, N,  SH, 16'd5);
    // resumed; ALU with halt_req raised in EXEC
    tick(5'b00010, 4'hF, RD, SB, 16'd5);
    tick(5'b00010, 4'h3, IP, SB, 16'd5);
    tick(5'b00110, 4'h3, AL, SB, 16'd5);
    tick(5'b01110, 4'h3, AC, SB, 16'd5);
    tick(5'b01110, 4'h3, N,  SH, 16'd6);
    tick(5'b01010, 4'h3, N,  SH, 16'd6);
    // fetch timeout: 15 cycles of mem_ready low, then FAULT until reset
    for (int i = 0; i < 15; i++) tick(5'b01000, 4'h3, RD, SB, 16'd6);
    tick(5'b01010, 4'h3, N,  SF, 16'd6);
    tick(5'b01010, 4'h3, N,  SF, 16'd6);
    tick(5'b11010, 4'h3, N,  SF, 16'd6);
    tick(5'b00010, 4'h0, N,  SI, 16'd0);
`ifdef SINGLE_STEP_EN
    tick(5'b01010, 4'h0, N,  SI, 16'd0);
    tick(5'b01010, 4'h0, RD, SB, 16'd0);
    tick(5'b01010, 4'hF, IP, SB, 16'd0);
    tick(5'b00010, 4'hF, N,  SB, 16'd0);
    tick(5'b00011, 4'hF, N,  SH, 16'd1);
    tick(5'b01010, 4'hF, RD, SB, 16'd1);
    tick(5'b01010, 4'h0, IP, SB, 16'd1);
    tick(5'b01010, 4'h0, N,  SB, 16'd1);
    tick(5'b00010, 4'h0, N,  SH, 16'd2);
    tick(5'b00010, 4'h0, N,  SH, 16'd2);
`endif
    @(negedge clk_in);
    @(negedge clk_in);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d entries left, need 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
